// File: rtl/sc_spi_pkg.sv
// Shared definitions for the SPI transfer sequencer: state encoding,
// buffer geometry and the inter-frame gap length used in poll mode.
package sc_spi_pkg;

    localparam int BUF_DEPTH = 16;
    localparam int PTR_W     = 4;
    localparam int GAP_CYC   = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAITB = 3'd2,
        RUN   = 3'd3,
        EVAL  = 3'd4,
        GAP   = 3'd5,
        FIN   = 3'd6
    } state_t;

endpackage

// File: rtl/sc_spi_dpbuf.sv
// 16x32 register-array buffer: one write port, one combinational read port
// and one registered read port that holds its value when not enabled.
module sc_spi_dpbuf
    import sc_spi_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_wadr,
    input  logic [31:0]      i_wdat,
    input  logic [PTR_W-1:0] i_cadr,
    output logic [31:0]      o_cdat,
    input  logic             i_re,
    input  logic [PTR_W-1:0] i_radr,
    output logic [31:0]      o_rdat
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdat;

    // Registered read samples the pre-write contents on a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdat <= '0;
        end else begin
            if (i_we) begin
                r_mem[i_wadr] <= i_wdat;
            end
            if (i_re) begin
                r_rdat <= r_mem[i_radr];
            end
        end
    end

    assign o_cdat = r_mem[i_cadr];
    assign o_rdat = r_rdat;

endmodule

// File: rtl/sc_spi_xfer_seq.sv
// Transfer sequencer ahead of the SPI controller: TX/RX word buffers,
// SPISTART handshake, CS extension and repeat-until-match status polling.
module sc_spi_xfer_seq
    import sc_spi_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH,
    parameter int PCW   = 8
) (
    input  logic             SPICLK,
    input  logic             SYSRST,
    input  logic             BUFWE,
    input  logic [PTR_W-1:0] BUFWADR,
    input  logic [31:0]      BUFWDAT,
    input  logic             BUFRE,
    input  logic [PTR_W-1:0] BUFRADR,
    output logic [31:0]      BUFRDAT,
    input  logic             REQ,
    input  logic             REQPOLL,
    input  logic             REQCSKEEP,
    input  logic             CSREL,
    input  logic [31:0]      POLLMASK,
    input  logic [31:0]      POLLVAL,
    input  logic [PCW-1:0]   POLLMAX,
    output logic             BUSY,
    output logic             DONE,
    output logic             MATCH,
    output logic             PTMO,
    output logic             WERR,
    output logic [PCW-1:0]   POLLCNT,
    output logic             SPISTART,
    input  logic             SPIBUSY,
    output logic             CSEXTEND,
    input  logic [PTR_W-1:0] TXDPT,
    output logic [31:0]      TXDATA,
    input  logic [31:0]      RXDATA,
    input  logic             RXVALID,
    input  logic [PTR_W-1:0] RXDPT
);

    state_t         r_state;
    logic           r_busy, r_done, r_match, r_ptmo, r_werr;
    logic           r_spistart, r_csext, r_poll, r_keep;
    logic [PCW-1:0] r_pollcnt, r_pmax;
    logic [31:0]    r_mask, r_val;
    logic [1:0]     r_gapcnt;

    logic           w_txwe, w_hit;
    logic [31:0]    w_pollword, w_tx_rdat_unused;

    assign w_txwe = BUFWE & ~r_busy;

    sc_spi_dpbuf #(.DEPTH(DEPTH)) u_txbuf (
        .clk    (SPICLK),
        .rst    (SYSRST),
        .i_we   (w_txwe),
        .i_wadr (BUFWADR),
        .i_wdat (BUFWDAT),
        .i_cadr (TXDPT),
        .o_cdat (TXDATA),
        .i_re   (1'b0),
        .i_radr ('0),
        .o_rdat (w_tx_rdat_unused)
    );

    // The poll word is exactly rxbuf[0]: both load on RXVALID at pointer 0
    // and both clear on reset, so the combinational port supplies it.
    sc_spi_dpbuf #(.DEPTH(DEPTH)) u_rxbuf (
        .clk    (SPICLK),
        .rst    (SYSRST),
        .i_we   (RXVALID),
        .i_wadr (RXDPT),
        .i_wdat (RXDATA),
        .i_cadr ('0),
        .o_cdat (w_pollword),
        .i_re   (BUFRE),
        .i_radr (BUFRADR),
        .o_rdat (BUFRDAT)
    );

    assign w_hit = ((w_pollword ^ r_val) & r_mask) == 32'd0;

    always_ff @(posedge SPICLK or posedge SYSRST) begin
        if (SYSRST) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_match    <= 1'b0;
            r_ptmo     <= 1'b0;
            r_werr     <= 1'b0;
            r_spistart <= 1'b0;
            r_csext    <= 1'b0;
            r_poll     <= 1'b0;
            r_keep     <= 1'b0;
            r_pollcnt  <= '0;
            r_pmax     <= '0;
            r_mask     <= '0;
            r_val      <= '0;
            r_gapcnt   <= '0;
        end else begin
            r_spistart <= 1'b0;
            r_done     <= 1'b0;
            if (BUFWE && r_busy) begin
                r_werr <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (REQ) begin
                        r_poll     <= REQPOLL;
                        r_keep     <= REQCSKEEP;
                        r_mask     <= POLLMASK;
                        r_val      <= POLLVAL;
                        r_pmax     <= (POLLMAX == '0) ? PCW'(1) : POLLMAX;
                        r_pollcnt  <= '0;
                        r_match    <= 1'b0;
                        r_ptmo     <= 1'b0;
                        r_werr     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_csext    <= REQCSKEEP;
                        r_spistart <= 1'b1;
                        r_state    <= START;
                    end else if (CSREL) begin
                        r_csext <= 1'b0;
                    end
                end
                START: begin
                    if (r_pollcnt != '1) begin
                        r_pollcnt <= r_pollcnt + 1'b1;
                    end
                    r_state <= WAITB;
                end
                WAITB: if (SPIBUSY) r_state <= RUN;
                RUN:   if (!SPIBUSY) r_state <= EVAL;
                EVAL: begin
                    if (!r_poll || w_hit || (r_pollcnt >= r_pmax)) begin
                        r_match <= r_poll & w_hit;
                        r_ptmo  <= r_poll & ~w_hit;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= FIN;
                    end else begin
                        r_csext  <= 1'b0;
                        r_gapcnt <= '0;
                        r_state  <= GAP;
                    end
                end
                GAP: begin
                    if (r_gapcnt == 2'(GAP_CYC - 1)) begin
                        r_csext    <= r_keep;
                        r_spistart <= 1'b1;
                        r_state    <= START;
                    end else begin
                        r_gapcnt <= r_gapcnt + 2'd1;
                    end
                end
                FIN:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign MATCH    = r_match;
    assign PTMO     = r_ptmo;
    assign WERR     = r_werr;
    assign POLLCNT  = r_pollcnt;
    assign SPISTART = r_spistart;
    assign CSEXTEND = r_csext;

endmodule

// File: tb/tb_sc_spi_xfer_seq.sv
// Randomised scoreboard bench for sc_spi_xfer_seq with a model SPI controller.
module tb_sc_spi_xfer_seq;

    localparam int PCW = 8;

    logic             SPICLK = 1'b0;
    logic             SYSRST = 1'b1;
    logic             BUFWE = 1'b0;
    logic [3:0]       BUFWADR = '0;
    logic [31:0]      BUFWDAT = '0;
    logic             BUFRE = 1'b0;
    logic [3:0]       BUFRADR = '0;
    logic [31:0]      BUFRDAT;
    logic             REQ = 1'b0, REQPOLL = 1'b0, REQCSKEEP = 1'b0, CSREL = 1'b0;
    logic [31:0]      POLLMASK = '0, POLLVAL = '0;
    logic [PCW-1:0]   POLLMAX = '0;
    logic             BUSY, DONE, MATCH, PTMO, WERR, SPISTART, CSEXTEND;
    logic [PCW-1:0]   POLLCNT;
    logic             SPIBUSY = 1'b0;
    logic [3:0]       TXDPT;
    logic [31:0]      TXDATA;
    logic [31:0]      RXDATA = '0;
    logic             RXVALID = 1'b0;
    logic [3:0]       RXDPT = '0;

    logic             ctl_active = 1'b0;
    logic [3:0]       ctl_dpt = '0, probe_dpt = '0;
    logic             rx_sent = 1'b0;
    assign TXDPT = ctl_active ? ctl_dpt : probe_dpt;

    always #5 SPICLK = ~SPICLK;

    sc_spi_xfer_seq #(.PCW(PCW)) dut (
        .SPICLK(SPICLK), .SYSRST(SYSRST),
        .BUFWE(BUFWE), .BUFWADR(BUFWADR), .BUFWDAT(BUFWDAT),
        .BUFRE(BUFRE), .BUFRADR(BUFRADR), .BUFRDAT(BUFRDAT),
        .REQ(REQ), .REQPOLL(REQPOLL), .REQCSKEEP(REQCSKEEP), .CSREL(CSREL),
        .POLLMASK(POLLMASK), .POLLVAL(POLLVAL), .POLLMAX(POLLMAX),
        .BUSY(BUSY), .DONE(DONE), .MATCH(MATCH), .PTMO(PTMO), .WERR(WERR),
        .POLLCNT(POLLCNT), .SPISTART(SPISTART), .SPIBUSY(SPIBUSY),
        .CSEXTEND(CSEXTEND), .TXDPT(TXDPT), .TXDATA(TXDATA),
        .RXDATA(RXDATA), .RXVALID(RXVALID), .RXDPT(RXDPT)
    );

    typedef struct {
        logic poll;
        logic keep;
        logic match;
        logic ptmo;
        int   frames;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] resp_q[$];
    logic [31:0] dir_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] model_tx[16];
    logic [31:0] model_rx[16];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // Model controller: one frame per SPISTART, 1..3 words, word 0 is the poll response.
    initial begin
        int nw;
        forever begin
            @(negedge SPICLK);
            if (SPISTART === 1'b1) begin
                nw = 1 + int'($urandom_range(0, 2));
                ctl_active = 1'b1;
                ctl_dpt = '0;
                @(negedge SPICLK);
                SPIBUSY = 1'b1;
                for (int k = 0; k < nw; k++) begin
                    ctl_dpt = 4'(k);
                    #1 chk($sformatf("txdata[%0d]", k), TXDATA, model_tx[k]);
                    @(negedge SPICLK);
                    RXDPT = 4'(k);
                    if (k == 0 && resp_q.size() > 0) RXDATA = resp_q.pop_front();
                    else RXDATA = $urandom();
                    RXVALID = 1'b1;
                    model_rx[k] = RXDATA;
                    $display("frame word %0d rx=%h", k, RXDATA);
                    @(negedge SPICLK);
                    RXVALID = 1'b0;
                end
                rx_sent = 1'b1;
                repeat (2) @(negedge SPICLK);
                SPIBUSY = 1'b0;
                rx_sent = 1'b0;
                ctl_active = 1'b0;
            end
        end
    end

    // Monitor: pops expectations on DONE and on each registered RX read.
    initial begin
        logic prev_busy, prev_re;
        int   frame_cnt, gap_low;
        exp_t e;
        prev_busy = 1'b0;
        prev_re = 1'b0;
        frame_cnt = 0;
        gap_low = 0;
        forever begin
            @(negedge SPICLK);
            #1;
            if (prev_re) begin
                if (rd_q.size() == 0) fail_now("rd scoreboard underflow");
                else chk("bufrdat", BUFRDAT, rd_q.pop_front());
            end
            prev_re = BUFRE;
            if (BUSY && !prev_busy) begin
                frame_cnt = 0;
                gap_low = 0;
            end
            prev_busy = BUSY;
            if (SPISTART) frame_cnt++;
            if (BUSY && !CSEXTEND) gap_low++;
            if (DONE) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected DONE");
                end else begin
                    e = exp_q.pop_front();
                    $display("done: match=%0b ptmo=%0b pollcnt=%0d frames=%0d", MATCH, PTMO, POLLCNT, frame_cnt);
                    chk("match", 32'(MATCH), 32'(e.match));
                    chk("ptmo", 32'(PTMO), 32'(e.ptmo));
                    chk("pollcnt", 32'(POLLCNT), 32'(e.frames));
                    chk("spistart_count", 32'(frame_cnt), 32'(e.frames));
                    chk("busy_at_done", 32'(BUSY), 32'd0);
                    chk("csext_at_done", 32'(CSEXTEND), 32'(e.keep));
                    if (e.keep) chk("gap_low_cycles", 32'(gap_low), 32'(2 * (e.frames - 1)));
                end
            end
        end
    end

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge SPICLK);
        BUFWE = 1'b1; BUFWADR = a; BUFWDAT = d;
        model_tx[a] = d;
        @(negedge SPICLK);
        BUFWE = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        @(negedge SPICLK);
        BUFRE = 1'b1; BUFRADR = a;
        rd_q.push_back(model_rx[a]);
        @(negedge SPICLK);
        BUFRE = 1'b0;
    endtask

    // Reference: a poll request repeats until a masked match or until the
    // frame count reaches max(POLLMAX,1); a plain request is a single frame.
    task automatic start_req(input logic poll, input logic keep, input logic [31:0] mask,
                             input logic [31:0] val, input logic [PCW-1:0] pmax);
        exp_t        e;
        int          lim;
        logic [31:0] r;
        logic        stop;
        lim = (pmax == 0) ? 1 : int'(pmax);
        e.poll = poll; e.keep = keep; e.match = 1'b0; e.ptmo = 1'b0; e.frames = 0;
        stop = 1'b0;
        while (!stop) begin
            if (dir_q.size() > 0) r = dir_q.pop_front();
            else if ($urandom_range(0, 2) == 0) r = (val & mask) | ($urandom() & ~mask);
            else r = $urandom();
            resp_q.push_back(r);
            e.frames++;
            if (!poll) stop = 1'b1;
            else if ((r & mask) == (val & mask)) begin e.match = 1'b1; stop = 1'b1; end
            else if (e.frames >= lim) begin e.ptmo = 1'b1; stop = 1'b1; end
        end
        exp_q.push_back(e);
        $display("req: poll=%0b keep=%0b mask=%h val=%h max=%0d -> frames=%0d match=%0b",
                 poll, keep, mask, val, pmax, e.frames, e.match);
        @(negedge SPICLK);
        REQ = 1'b1; REQPOLL = poll; REQCSKEEP = keep;
        POLLMASK = mask; POLLVAL = val; POLLMAX = pmax;
        @(negedge SPICLK);
        REQ = 1'b0; REQPOLL = 1'($urandom()); REQCSKEEP = 1'($urandom());
        POLLMASK = $urandom(); POLLVAL = $urandom();
    endtask

    task automatic wait_done();
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 600) begin
            @(negedge SPICLK);
            n++;
        end
        if (done_cnt == start) fail_now("done_timeout: no DONE within 600 cycles");
        repeat (2) @(negedge SPICLK);
    endtask

    task automatic wait_spibusy();
        int n;
        n = 0;
        while (SPIBUSY !== 1'b1 && n < 200) begin
            @(negedge SPICLK);
            n++;
        end
        if (SPIBUSY !== 1'b1) fail_now("spibusy_timeout: frame never started");
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) begin
            model_tx[i] = '0;
            model_rx[i] = '0;
        end
        repeat (3) @(negedge SPICLK);
        #1;
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_match", 32'(MATCH), 32'd0);
        chk("rst_ptmo", 32'(PTMO), 32'd0);
        chk("rst_werr", 32'(WERR), 32'd0);
        chk("rst_pollcnt", 32'(POLLCNT), 32'd0);
        chk("rst_spistart", 32'(SPISTART), 32'd0);
        chk("rst_csext", 32'(CSEXTEND), 32'd0);
        chk("rst_txdata", TXDATA, 32'd0);
        chk("rst_bufrdat", BUFRDAT, 32'd0);
        @(negedge SPICLK);
        SYSRST = 1'b0;

        // Single non-poll frame.
        wr(4'd0, 32'hA5A5_1234);
        dir_q.push_back(32'hDEAD_BEEF);
        start_req(1'b0, 1'b0, '0, '0, 8'd1);
        wait_done();
        rd(4'd0);
        chk("rxbuf0_directed", model_rx[0] ^ 32'hDEAD_BEEF, 32'd0);

        // Poll: bit0 must read 0; responses 3,3,2 match on the third frame.
        dir_q.push_back(32'h3); dir_q.push_back(32'h3); dir_q.push_back(32'h2);
        start_req(1'b1, 1'b1, 32'h1, 32'h0, 8'd5);
        wait_done();

        // Poll with POLLMAX=0 never matching: exactly one frame then timeout.
        dir_q.push_back(32'h1);
        start_req(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 8'd0);
        wait_done();

        // CS keep, release ignored while busy, honoured in idle.
        start_req(1'b0, 1'b1, '0, '0, 8'd1);
        wait_spibusy();
        CSREL = 1'b1;
        @(negedge SPICLK);
        CSREL = 1'b0;
        wait_done();
        #1 chk("csext_kept_idle", 32'(CSEXTEND), 32'd1);
        @(negedge SPICLK);
        CSREL = 1'b1;
        @(negedge SPICLK);
        CSREL = 1'b0;
        #1 chk("csext_released", 32'(CSEXTEND), 32'd0);

        // Host write and second REQ while busy are both dropped.
        wr(4'd2, 32'h1111_2222);
        start_req(1'b0, 1'b0, '0, '0, 8'd1);
        wait_spibusy();
        @(negedge SPICLK);
        BUFWE = 1'b1; BUFWADR = 4'd2; BUFWDAT = 32'h5555_AAAA;
        REQ = 1'b1;
        @(negedge SPICLK);
        BUFWE = 1'b0; REQ = 1'b0;
        #1 chk("werr_set", 32'(WERR), 32'd1);
        wait_done();
        probe_dpt = 4'd2;
        #1 chk("txbuf2_unchanged", TXDATA, model_tx[2]);
        start_req(1'b0, 1'b0, '0, '0, 8'd1);
        #1 chk("werr_cleared", 32'(WERR), 32'd0);
        wait_done();

        // Reset in RUN after the frame data landed.
        start_req(1'b0, 1'b1, '0, '0, 8'd1);
        n = 0;
        while (!rx_sent && n < 200) begin
            @(negedge SPICLK);
            #2;
            n++;
        end
        if (!rx_sent) fail_now("rx_sent_timeout");
        SYSRST = 1'b1;
        #1;
        chk("arst_busy", 32'(BUSY), 32'd0);
        chk("arst_spistart", 32'(SPISTART), 32'd0);
        chk("arst_csext", 32'(CSEXTEND), 32'd0);
        chk("arst_done", 32'(DONE), 32'd0);
        for (int i = 0; i < 16; i++) begin
            model_tx[i] = '0;
            model_rx[i] = '0;
        end
        exp_q.delete();
        resp_q.delete();
        dir_q.delete();
        @(negedge SPICLK);
        SYSRST = 1'b0;
        n = 0;
        while (ctl_active && n < 200) begin
            @(negedge SPICLK);
            n++;
        end
        rd(4'd0);
        rd(4'd1);
        start_req(1'b0, 1'b0, '0, '0, 8'd1);
        wait_done();

        // Randomised traffic.
        for (int t = 0; t < 12; t++) begin
            wr(4'($urandom_range(0, 15)), $urandom());
            wr(4'($urandom_range(0, 2)), $urandom());
            start_req(1'($urandom()), 1'($urandom()), $urandom() & $urandom() & $urandom(),
                      $urandom(), PCW'($urandom_range(0, 5)));
            wait_done();
            rd(4'($urandom_range(0, 3)));
            rd(4'($urandom_range(0, 15)));
        end

        repeat (4) @(negedge SPICLK);
        if (exp_q.size() != 0) fail_now("requests left without DONE");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
